seq_restoring_divider: RTL and testbench
========================================

Name: seq_restoring_divider

Overview:
Multi-cycle unsigned integer divider built on repeated trial subtraction. It is the inverse-operation companion to the team's combinational carry-lookahead adder. It accepts one dividend/divisor pair per start pulse and retires one quotient bit per clock. A start/busy/done handshake lets datapath controllers chain it behind adder results.

Parameters:
n, 8, operand width in bits for dividend, divisor, quotient and remainder (n >= 2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request pulse; sampled only when busy=0
dividend  input  n  unsigned dividend, captured when start is accepted
divisor  input  n  unsigned divisor, captured when start is accepted
busy  output  1  high while an operation is in progress
done  output  1  single-cycle pulse: result registers just updated
quotient  output  n  registered quotient, held until the next result
remainder  output  n  registered remainder, held until the next result
div_by_zero  output  1  registered flag for the last result; high if divisor was 0

Behaviour:
- Reset (async, rst=1): state=IDLE; busy, done, div_by_zero=0; quotient, remainder=0; working registers=0. Reset mid-operation aborts immediately with no done pulse.
- States and transitions:
  - IDLE: start=1 and divisor!=0 -> RUN; start=1 and divisor==0 -> DONE (zero-divisor result).
  - RUN: n cycles, tracked by an iteration counter of width ceil(log2(n+1)). The last iteration -> DONE.
  - DONE: lasts one cycle, then -> IDLE. start=1 in DONE is accepted exactly as in IDLE, giving back-to-back operation with no bubble.
- busy=1 exactly while state=RUN. done=1 exactly while state=DONE.
- Start acceptance: start is accepted when state is IDLE or DONE. start during RUN is ignored and has no side effects. Operands are sampled only on the accepting edge, so later input changes do not matter.
- Iteration (each RUN cycle), using working registers R (n+1 bits), Q (n bits) and D (n bits):
  - shifted = {R[n-1:0], Q[n-1]}
  - trial = shifted - {0, D}, computed n+1 bits wide
  - if trial has no borrow: R <= trial and Q <= {Q[n-2:0], 1}
  - otherwise: R <= shifted and Q <= {Q[n-2:0], 0}
  - Initial values: R=0, Q=dividend, D=divisor.
- Result update on the edge entering DONE:
  - normal case: quotient <= Q, remainder <= R[n-1:0], div_by_zero <= 0
  - zero-divisor case: quotient <= all ones, remainder <= dividend, div_by_zero <= 1
- Latency: start accepted on edge k.
  - Normal: done=1 during the cycle after edge k+n.
  - Zero divisor: done=1 during the cycle after edge k.
- Outputs quotient, remainder and div_by_zero change only on entry to DONE or on reset, and are stable between results.
- Edge cases:
  - dividend < divisor: quotient=0, remainder=dividend.
  - divisor=1: quotient=dividend, remainder=0.
  - Full-scale operands work with no overflow, because trial is computed n+1 bits wide.

Decomposition:
- Shared package holds:
  - state enum {IDLE, RUN, DONE}, 2-bit encoding
  - function computing the iteration-counter width from n
  - constant for the zero-divisor quotient value (all ones)
- One sub-module: trial_subtractor. It is combinational and parameterized on width w=n+1, with inputs a and b and outputs diff and borrow_out. It is implemented as a lookahead borrow chain using generate/propagate terms (p = ~a ^ b form), mirroring the adder's structure. The top level instantiates it once.

Test Plan:
- Reset, then dividend=200, divisor=7, one-cycle start -> busy for 8 cycles; done pulse 8 cycles after the start edge; quotient=28, remainder=4, div_by_zero=0.
- dividend=255, divisor=1 -> quotient=255, remainder=0. Then dividend=5, divisor=9 -> quotient=0, remainder=5.
- dividend=77, divisor=0 -> done one cycle after start; quotient=8'hFF, remainder=77, div_by_zero=1, busy never high.
- Start 100/10. Pulse start with 9/3 while busy -> ignored; result is 10 r 0. Then assert start during the DONE cycle with 9/3 -> accepted; next result is 3 r 0 with no idle cycle.
- Start 250/13, assert rst for one cycle at iteration 4 -> all outputs 0 immediately, no done pulse. A fresh 250/13 then gives 19 r 3.
- Random sweep of 1000 pairs, including 0, 1 and 255 on each operand -> quotient*divisor+remainder=dividend and remainder<divisor for every nonzero divisor.

Source files
------------

// File: rtl/seq_restoring_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_restoring_divider_pkg;

  // Controller states, 2-bit encoding
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // The quotient reported for a zero divisor is all ones. The top level
  // slices the low n bits, so operand widths up to 64 bits are supported.
  localparam logic [63:0] ZERO_DIV_QUOT = {64{1'b1}};

  // Width of an iteration counter able to hold the values 0..n
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_restoring_divider_trial_subtractor.sv
// Combinational w-bit subtractor with a lookahead borrow chain.
// A borrow is generated at a bit when a=0 and b=1. A borrow from below is
// passed on when a and b are equal (p = ~a ^ b). This mirrors the
// generate/propagate structure of the carry-lookahead adder.
module trial_subtractor #(
  parameter int w = 9
) (
  input  logic [w-1:0] a,
  input  logic [w-1:0] b,
  output logic [w-1:0] diff,
  output logic         borrow_out
);

  logic [w-1:0] g_s;
  logic [w-1:0] p_s;
  logic [w:0]   borrow_s;
  logic         acc_s;
  logic         pp_s;

  assign g_s = ~a & b;
  assign p_s = ~a ^ b;

  // Each borrow is the OR of the generate terms below it, each masked by the
  // propagate terms between that bit and this one. No bit waits on a rippled borrow.
  always_comb begin
    borrow_s = {(w + 1){1'b0}};
    acc_s    = 1'b0;
    pp_s     = 1'b1;
    for (int i = 0; i < w; i++) begin
      acc_s = 1'b0;
      pp_s  = 1'b1;
      for (int j = i; j >= 0; j--) begin
        acc_s = acc_s | (pp_s & g_s[j]);
        pp_s  = pp_s & p_s[j];
      end
      borrow_s[i+1] = acc_s;
    end
  end

  assign diff       = a ^ b ^ borrow_s[w-1:0];
  assign borrow_out = borrow_s[w];

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock,
// with a start/busy/done handshake and a zero-divisor shortcut.
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [n-1:0] dividend,
  input  logic [n-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] quotient,
  output logic [n-1:0] remainder,
  output logic         div_by_zero
);

  localparam int             CW       = cnt_width(n);
  localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]  CNT_ONE  = {{(CW - 1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]  CNT_LAST = CW'(n - 1);

  state_t         state_r;
  state_t         state_nxt_s;
  logic [CW-1:0]  cnt_r;
  logic [n:0]     r_r;
  logic [n-1:0]   q_r;
  logic [n-1:0]   d_r;
  logic           busy_r;
  logic           done_r;
  logic [n-1:0]   quotient_r;
  logic [n-1:0]   remainder_r;
  logic           div_by_zero_r;

  logic           accept_s;
  logic           zero_div_s;
  logic           last_iter_s;
  logic [n:0]     shifted_s;
  logic [n:0]     trial_s;
  logic           borrow_s;
  logic [n:0]     r_iter_s;
  logic [n-1:0]   q_iter_s;

  // Starts are accepted only while idle or during the done cycle.
  assign accept_s    = start & ((state_r == IDLE) | (state_r == DONE));
  assign zero_div_s  = (divisor == {n{1'b0}});
  assign last_iter_s = (state_r == RUN) & (cnt_r == CNT_LAST);

  // One restoring step: shift the next dividend bit into R, then try D.
  assign shifted_s = {r_r[n-1:0], q_r[n-1]};

  trial_subtractor #(
    .w (n + 1)
  ) u_trial (
    .a          (shifted_s),
    .b          ({1'b0, d_r}),
    .diff       (trial_s),
    .borrow_out (borrow_s)
  );

  // Keep the trial result when it did not borrow. Otherwise restore the shifted value.
  always_comb begin
    r_iter_s = shifted_s;
    q_iter_s = {q_r[n-2:0], 1'b0};
    if (!borrow_s) begin
      r_iter_s = trial_s;
      q_iter_s = {q_r[n-2:0], 1'b1};
    end else begin
      r_iter_s = shifted_s;
      q_iter_s = {q_r[n-2:0], 1'b0};
    end
  end

  // Next-state logic for the IDLE -> RUN -> DONE controller
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (accept_s) begin
          if (zero_div_s) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = RUN;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (last_iter_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register plus registered busy/done, decoded from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == RUN);
      done_r  <= (state_nxt_s == DONE);
    end
  end

  // Working registers: load on accept, iterate while running, else hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_r   <= {(n + 1){1'b0}};
      q_r   <= {n{1'b0}};
      d_r   <= {n{1'b0}};
      cnt_r <= CNT_ZERO;
    end else if (accept_s) begin
      r_r   <= {(n + 1){1'b0}};
      q_r   <= dividend;
      d_r   <= divisor;
      cnt_r <= CNT_ZERO;
    end else if (state_r == RUN) begin
      r_r   <= r_iter_s;
      q_r   <= q_iter_s;
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      r_r   <= r_r;
      q_r   <= q_r;
      d_r   <= d_r;
      cnt_r <= cnt_r;
    end
  end

  // Result registers change only on the edge that enters DONE.
  // On the last iteration they take the just-computed step values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quotient_r    <= {n{1'b0}};
      remainder_r   <= {n{1'b0}};
      div_by_zero_r <= 1'b0;
    end else if (last_iter_s) begin
      quotient_r    <= q_iter_s;
      remainder_r   <= r_iter_s[n-1:0];
      div_by_zero_r <= 1'b0;
    end else if (accept_s && zero_div_s) begin
      quotient_r    <= ZERO_DIV_QUOT[n-1:0];
      remainder_r   <= dividend;
      div_by_zero_r <= 1'b1;
    end else begin
      quotient_r    <= quotient_r;
      remainder_r   <= remainder_r;
      div_by_zero_r <= div_by_zero_r;
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign div_by_zero = div_by_zero_r;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed table-driven bench for seq_restoring_divider (n = 8), plus
// hand sequences for busy-ignore, back-to-back start, mid-run reset and a
// bounded random sweep checked against the division identity.
module tb_seq_restoring_divider;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  int n_cmp;
  int n_err;

  seq_restoring_divider #(.n(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] dvd;
    logic [N-1:0] dsr;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         z;
    int           lat;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Present operands with start for one edge. Returns at #1 after the accepting edge.
  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;
  endtask

  // Advance edge by edge until done is seen, with a bound.
  task automatic wait_done(output int lat, output int busyc);
    lat   = 0;
    busyc = 0;
    while (!done && lat < 40) begin
      if (busy) busyc++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (!done) check("done_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    int lat;
    int busyc;
    int lat_a;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] eq;
    logic [N-1:0] er;
    logic         ok;

    n_cmp = 0;
    n_err = 0;

    vecs[0] = '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 8};
    vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 8};
    vecs[2] = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 8};
    vecs[3] = '{8'd77,  8'd0,   8'hFF,  8'd77,  1'b1, 0};
    vecs[4] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 8};
    vecs[5] = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0, 8};
    vecs[6] = '{8'd255, 8'd16,  8'd15,  8'd15,  1'b0, 8};
    vecs[7] = '{8'd128, 8'd2,   8'd64,  8'd0,   1'b0, 8};
    vecs[8] = '{8'd1,   8'd255, 8'd0,   8'd1,   1'b0, 8};
    vecs[9] = '{8'd0,   8'd0,   8'hFF,  8'd0,   1'b1, 0};

    rst      = 1'b1;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_quotient", 32'(quotient), 32'd0);
    check("reset_remainder", 32'(remainder), 32'd0);
    check("reset_dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      start_op(vecs[i].dvd, vecs[i].dsr);
      wait_done(lat, busyc);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_busy_cycles", i), 32'(busyc), 32'(vecs[i].lat));
      check($sformatf("v%0d_quotient", i), 32'(quotient), 32'(vecs[i].q));
      check($sformatf("v%0d_remainder", i), 32'(remainder), 32'(vecs[i].r));
      check($sformatf("v%0d_dbz", i), 32'(div_by_zero), 32'(vecs[i].z));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_done_single", i), 32'(done), 32'd0);
      check($sformatf("v%0d_quotient_hold", i), 32'(quotient), 32'(vecs[i].q));
    end

    // start while busy is ignored
    start_op(8'd100, 8'd10);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    start_op(8'd9, 8'd3);
    check("ignored_busy", 32'(busy), 32'd1);
    wait_done(lat, busyc);
    check("ignored_latency", 32'(lat + 4), 32'd8);
    check("ignored_quotient", 32'(quotient), 32'd10);
    check("ignored_remainder", 32'(remainder), 32'd0);

    // start during the done cycle: accepted with no bubble
    start_op(8'd9, 8'd3);
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_done", 32'(done), 32'd0);
    check("b2b_quotient_held", 32'(quotient), 32'd10);
    wait_done(lat, busyc);
    check("b2b_latency", 32'(lat), 32'd8);
    check("b2b_quotient", 32'(quotient), 32'd3);
    check("b2b_remainder", 32'(remainder), 32'd0);

    // Reset at iteration 4 aborts the run
    start_op(8'd250, 8'd13);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_quotient", 32'(quotient), 32'd0);
    check("abort_remainder", 32'(remainder), 32'd0);
    check("abort_dbz", 32'(div_by_zero), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) ok = 1'b0;
    end
    check("abort_no_done", 32'(ok), 32'd1);
    start_op(8'd250, 8'd13);
    wait_done(lat, busyc);
    check("fresh_latency", 32'(lat), 32'd8);
    check("fresh_quotient", 32'(quotient), 32'd19);
    check("fresh_remainder", 32'(remainder), 32'd3);

    // Random sweep with corner operands mixed in
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 5))
        0: a = 8'd0;
        1: a = 8'd1;
        2: a = 8'd255;
        default: a = 8'($urandom_range(0, 255));
      endcase
      case ($urandom_range(0, 5))
        0: b = 8'd0;
        1: b = 8'd1;
        2: b = 8'd255;
        default: b = 8'($urandom_range(0, 255));
      endcase
      start_op(a, b);
      wait_done(lat, busyc);
      if (b == 8'd0) begin
        eq    = 8'hFF;
        er    = a;
        lat_a = 0;
      end else begin
        eq    = a / b;
        er    = a % b;
        lat_a = 8;
      end
      ok = (quotient == eq) && (remainder == er) && (div_by_zero == (b == 8'd0)) && (lat == lat_a);
      if (b != 8'd0) begin
        ok = ok && ((32'(quotient) * 32'(b) + 32'(remainder)) == 32'(a)) && (remainder < b);
      end
      n_cmp++;
      if (!ok) begin
        n_err++;
        $display("FAIL sweep %0d/%0d: got q=%0d r=%0d z=%0d lat=%0d, expected q=%0d r=%0d z=%0d lat=%0d",
                 a, b, quotient, remainder, div_by_zero, lat, eq, er, (b == 8'd0), lat_a);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
